// File: rtl/dmem_responder.sv
// Data-memory responder: combinational core reads, clocked core writes, and a
// four-phase debug peek/poke port. Optional range checking: DMEM_BOUNDS_CHECK_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        dmem_read_wrn,
    input  logic [15:0] dmem_address_bus,
    input  logic [31:0] dmem_data_wr,
    output logic [31:0] dmem_data_rd,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        collision_err,
    output logic        bounds_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t state;
    state_t state_next;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] core_idx;
    logic [ADDR_WIDTH-1:0] dbg_idx;
    logic                  core_ok;
    logic                  dbg_ok;
    logic                  core_wr_try;
    logic                  core_we;
    logic                  dbg_access;
    logic                  dbg_wr_fire;
    logic                  unused_addr_bits;

    assign core_idx = dmem_address_bus[ADDR_WIDTH+1:2];
    assign dbg_idx  = dbg_addr[ADDR_WIDTH+1:2];

    // Byte-offset bits (and upper bits in the wrapping build) carry no meaning.
    assign unused_addr_bits = ^{dmem_address_bus, dbg_addr};

`ifdef DMEM_BOUNDS_CHECK_EN
    assign core_ok = (dmem_address_bus[15:ADDR_WIDTH+2] == '0);
    assign dbg_ok  = (dbg_addr[15:ADDR_WIDTH+2] == '0);
`else
    assign core_ok = 1'b1;
    assign dbg_ok  = 1'b1;
`endif

    assign core_wr_try = !dmem_read_wrn && !halt;
    assign core_we     = core_wr_try && (state == IDLE) && core_ok;
    assign dbg_access  = (state == ACCESS);
    assign dbg_wr_fire = dbg_access && dbg_we && dbg_ok;

    assign dmem_data_rd = core_ok ? mem[core_idx] : 32'h0;

    // Core and debug writes are mutually exclusive: core writes need IDLE.
    always_ff @(posedge clk) begin
        if (core_we) begin
            mem[core_idx] <= dmem_data_wr;
        end else if (dbg_wr_fire) begin
            mem[dbg_idx] <= dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dbg_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (dbg_req && halt) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = ACK;
            end
            ACK: begin
                dbg_ack = 1'b1;
                if (!dbg_req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata     <= 32'h0;
            collision_err <= 1'b0;
        end else begin
            if (dbg_access && !dbg_we) begin
                dbg_rdata <= dbg_ok ? mem[dbg_idx] : 32'h0;
            end
            if (core_wr_try && core_ok && (state != IDLE)) begin
                collision_err <= 1'b1;
            end
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bounds_err <= 1'b0;
        end else if ((core_wr_try && !core_ok) || (dmem_read_wrn && !core_ok) ||
                     (dbg_access && !dbg_ok)) begin
            bounds_err <= 1'b1;
        end
    end
`else
    assign bounds_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: word-level memory model plus directed
// scenarios (core read/write, halted store, debug port, collision, wrap, reset).
module tb_dmem_responder;

    localparam int AW = 10;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_ON = 1'b1;
`else
    localparam bit BOUNDS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        halt = 1'b0;
    logic        dmem_read_wrn = 1'b1;
    logic [15:0] dmem_address_bus = 16'h0;
    logic [31:0] dmem_data_wr = 32'h0;
    logic [31:0] dmem_data_rd;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [15:0] dbg_addr = 16'h0;
    logic [31:0] dbg_wdata = 32'h0;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        collision_err;
    logic        bounds_err;

    int total = 0;
    int bad = 0;

    logic [31:0] m_mem [1 << AW];
    bit          m_valid [1 << AW];
    int          m_phase = 0;
    int          m_cur;
    logic [31:0] m_rdata = 32'h0;
    bit          m_coll = 1'b0;
    bit          m_bounds = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .halt(halt),
        .dmem_read_wrn(dmem_read_wrn),
        .dmem_address_bus(dmem_address_bus),
        .dmem_data_wr(dmem_data_wr),
        .dmem_data_rd(dmem_data_rd),
        .dbg_req(dbg_req),
        .dbg_we(dbg_we),
        .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack),
        .dbg_rdata(dbg_rdata),
        .collision_err(collision_err),
        .bounds_err(bounds_err)
    );

    function automatic bit in_range(input logic [15:0] a);
        return !BOUNDS_ON || (a[15:AW+2] == 4'h0);
    endfunction

    function automatic int widx(input logic [15:0] a);
        return int'(a[AW+1:2]);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic rwn, input logic [15:0] a, input logic [31:0] d);
        dmem_read_wrn    = rwn;
        dmem_address_bus = a;
        dmem_data_wr     = d;
    endtask

    task automatic next_cycle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Reference model: memory contents, transaction progress (0 idle, 1 access, 2 ack) and flags.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  = 0;
            m_rdata  = 32'h0;
            m_coll   = 1'b0;
            m_bounds = 1'b0;
        end else begin
            m_cur = m_phase;
            if (!dmem_read_wrn && !halt) begin
                if (!in_range(dmem_address_bus)) begin
                    m_bounds = 1'b1;
                end else if (m_cur == 0) begin
                    m_mem[widx(dmem_address_bus)]   = dmem_data_wr;
                    m_valid[widx(dmem_address_bus)] = 1'b1;
                end else begin
                    m_coll = 1'b1;
                end
            end
            if (dmem_read_wrn && !in_range(dmem_address_bus)) m_bounds = 1'b1;
            if (m_cur == 0) begin
                if (dbg_req && halt) m_phase = 1;
            end else if (m_cur == 1) begin
                if (!in_range(dbg_addr)) begin
                    m_bounds = 1'b1;
                    if (!dbg_we) m_rdata = 32'h0;
                end else if (dbg_we) begin
                    m_mem[widx(dbg_addr)]   = dbg_wdata;
                    m_valid[widx(dbg_addr)] = 1'b1;
                end else begin
                    m_rdata = m_mem[widx(dbg_addr)];
                end
                m_phase = 2;
            end else if (!dbg_req) begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        check_output("ack", {31'b0, dbg_ack}, {31'b0, m_phase == 2});
        check_output("rdata", dbg_rdata, m_rdata);
        check_output("collision", {31'b0, collision_err}, {31'b0, m_coll});
        check_output("bounds", {31'b0, bounds_err}, {31'b0, m_bounds});
        if (!in_range(dmem_address_bus)) begin
            check_output("core_rd_oor", dmem_data_rd, 32'h0);
        end else if (m_valid[widx(dmem_address_bus)]) begin
            check_output("core_rd", dmem_data_rd, m_mem[widx(dmem_address_bus)]);
        end
    end

    logic [15:0] vec_addr [4] = '{16'h0100, 16'h0104, 16'h0FFC, 16'h0200};
    logic [31:0] vec_data [4] = '{32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h00000001};

    initial begin
        #1 rst_n = 1'b0;
        next_cycle(2);
        check_output("reset_ack", {31'b0, dbg_ack}, 32'h0);
        check_output("reset_rdata", dbg_rdata, 32'h0);
        check_output("reset_coll", {31'b0, collision_err}, 32'h0);
        check_output("reset_bounds", {31'b0, bounds_err}, 32'h0);
        rst_n = 1'b1;

        apply_stimulus(1'b0, 16'h0010, 32'hDEADBEEF);
        next_cycle(1);
        apply_stimulus(1'b1, 16'h0012, 32'h0);
        #1 check_output("wr_then_rd", dmem_data_rd, 32'hDEADBEEF);

        apply_stimulus(1'b0, 16'h0020, 32'h11111111);
        next_cycle(1);
        halt = 1'b1;
        apply_stimulus(1'b0, 16'h0020, 32'h00001234);
        next_cycle(2);
        check_output("halted_store", dmem_data_rd, 32'h11111111);
        halt = 1'b0;
        next_cycle(1);
        check_output("store_after_halt", dmem_data_rd, 32'h00001234);
        apply_stimulus(1'b1, 16'h0020, 32'h0);

        halt      = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 16'h0040;
        dbg_wdata = 32'hCAFEF00D;
        dbg_req   = 1'b1;
        next_cycle(1);
        check_output("ack_in_access", {31'b0, dbg_ack}, 32'h0);
        next_cycle(1);
        check_output("ack_at_n2", {31'b0, dbg_ack}, 32'h1);
        dbg_req = 1'b0;
        next_cycle(1);
        check_output("ack_released", {31'b0, dbg_ack}, 32'h0);
        apply_stimulus(1'b1, 16'h0040, 32'h0);
        #1 check_output("core_sees_dbg_wr", dmem_data_rd, 32'hCAFEF00D);

        dbg_we  = 1'b0;
        dbg_req = 1'b1;
        next_cycle(2);
        check_output("dbg_read_ack", {31'b0, dbg_ack}, 32'h1);
        check_output("dbg_read_data", dbg_rdata, 32'hCAFEF00D);

        halt = 1'b0;
        apply_stimulus(1'b0, 16'h0040, 32'h00005555);
        next_cycle(1);
        apply_stimulus(1'b1, 16'h0040, 32'h0);
        #1 check_output("collision_word", dmem_data_rd, 32'hCAFEF00D);
        check_output("collision_flag", {31'b0, collision_err}, 32'h1);
        dbg_req = 1'b0;
        next_cycle(2);

        apply_stimulus(1'b0, 16'h0004, 32'h0BADF00D);
        next_cycle(1);
        apply_stimulus(1'b0, 16'h1004, 32'h0000AAAA);
        next_cycle(1);
        apply_stimulus(1'b1, 16'h0004, 32'h0);
        #1 check_output("wrap_word", dmem_data_rd, BOUNDS_ON ? 32'h0BADF00D : 32'h0000AAAA);
        check_output("wrap_bounds", {31'b0, bounds_err}, {31'b0, BOUNDS_ON});

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, vec_addr[i], vec_data[i]);
            next_cycle(1);
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, vec_addr[i], 32'h0);
            #1 check_output("vector_rd", dmem_data_rd, vec_data[i]);
            next_cycle(1);
        end

        halt      = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 16'h0048;
        dbg_wdata = 32'h00000077;
        dbg_req   = 1'b1;
        next_cycle(1);
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_ack", {31'b0, dbg_ack}, 32'h0);
        check_output("rst_mid_rdata", dbg_rdata, 32'h0);
        check_output("rst_mid_coll", {31'b0, collision_err}, 32'h0);
        dbg_req = 1'b0;
        halt    = 1'b0;
        next_cycle(1);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 16'h0040, 32'h0);
        #1 check_output("mem_kept_40", dmem_data_rd, 32'hCAFEF00D);
        apply_stimulus(1'b1, 16'h0010, 32'h0);
        #1 check_output("mem_kept_10", dmem_data_rd, 32'hDEADBEEF);
        next_cycle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
